// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, masters the instruction bus with req/ack,
// and hands {pc, inst} to IF/ID while honouring branch delay slots and flush redirects.
module if_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_INC   = 32'd4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  stall,
    input  logic        branch_flag_i,
    input  logic [31:0] branch_target_i,
    input  logic        flush,
    input  logic [31:0] new_pc,
    output logic        ibus_req,
    output logic [31:0] ibus_addr,
    input  logic        ibus_ack,
    input  logic [31:0] ibus_rdata,
    output logic        stallreq,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst
);

    typedef enum logic [1:0] {IDLE, FETCH, DISCARD, READY} state_t;

    state_t      state, state_n;
    logic [31:0] pc, pc_n;
    logic [31:0] inst_buf, inst_buf_n;
    logic        pend_br, pend_br_n;
    logic [31:0] pend_tgt, pend_tgt_n;

    // Only the IF hold bit matters to this stage.
    logic unused_stall;
    assign unused_stall = ^stall[5:1];

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            pc       <= RESET_PC;
            inst_buf <= '0;
            pend_br  <= 1'b0;
            pend_tgt <= '0;
        end else begin
            state    <= state_n;
            pc       <= pc_n;
            inst_buf <= inst_buf_n;
            pend_br  <= pend_br_n;
            pend_tgt <= pend_tgt_n;
        end
    end

    always_comb begin
        state_n    = state;
        pc_n       = pc;
        inst_buf_n = inst_buf;
        pend_br_n  = pend_br;
        pend_tgt_n = pend_tgt;
        unique case (state)
            IDLE: state_n = FETCH;
            FETCH: begin
                if (flush) begin
                    pend_br_n = 1'b0;
                    pc_n      = new_pc;
                    state_n   = ibus_ack ? FETCH : DISCARD;
                end else begin
                    // The outstanding fetch is the delay slot; keep it and remember the target.
                    if (branch_flag_i) begin
                        pend_br_n  = 1'b1;
                        pend_tgt_n = branch_target_i;
                    end
                    if (ibus_ack) begin
                        inst_buf_n = ibus_rdata;
                        state_n    = READY;
                    end
                end
            end
            DISCARD: begin
                if (flush)
                    pc_n = new_pc;
                if (ibus_ack)
                    state_n = FETCH;
            end
            READY: begin
                if (flush) begin
                    pc_n      = new_pc;
                    pend_br_n = 1'b0;
                    state_n   = FETCH;
                end else if (stall[0]) begin
                    if (branch_flag_i) begin
                        pend_br_n  = 1'b1;
                        pend_tgt_n = branch_target_i;
                    end
                end else begin
                    if (branch_flag_i)
                        pc_n = branch_target_i;
                    else if (pend_br)
                        pc_n = pend_tgt;
                    else
                        pc_n = pc + PC_INC;
                    pend_br_n = 1'b0;
                    state_n   = FETCH;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        ibus_req  = 1'b0;
        ibus_addr = '0;
        stallreq  = 1'b0;
        if_pc     = '0;
        if_inst   = '0;
        if (state == FETCH || state == DISCARD) begin
            ibus_req  = 1'b1;
            ibus_addr = pc;
            stallreq  = 1'b1;
        end
        if (state == READY) begin
            if_pc   = pc;
            if_inst = inst_buf;
        end
    end

endmodule

// File: tb/tb_if_fetch.sv
// Directed self-checking bench for if_fetch; the test drives the bus slave by hand.
module tb_if_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall;
    logic        branch_flag_i;
    logic [31:0] branch_target_i;
    logic        flush;
    logic [31:0] new_pc;
    logic        ibus_req;
    logic [31:0] ibus_addr;
    logic        ibus_ack;
    logic [31:0] ibus_rdata;
    logic        stallreq;
    logic [31:0] if_pc;
    logic [31:0] if_inst;

    int checks = 0;
    int errors = 0;

    if_fetch #(.RESET_PC(32'h0000_0000), .PC_INC(32'd4)) dut (
        .clk(clk), .rst(rst), .stall(stall),
        .branch_flag_i(branch_flag_i), .branch_target_i(branch_target_i),
        .flush(flush), .new_pc(new_pc),
        .ibus_req(ibus_req), .ibus_addr(ibus_addr),
        .ibus_ack(ibus_ack), .ibus_rdata(ibus_rdata),
        .stallreq(stallreq), .if_pc(if_pc), .if_inst(if_inst)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Entered while observing FETCH of addr: ack it, check READY, move to next FETCH.
    task automatic fetch_one(input string tag, input logic [31:0] addr, input logic [31:0] data);
        chk({tag, "_addr"}, ibus_addr, addr);
        chk({tag, "_req"}, {31'd0, ibus_req}, 32'd1);
        ibus_ack = 1'b1; ibus_rdata = data;
        tick();
        ibus_ack = 1'b0; ibus_rdata = 32'hDEAD_BEEF;
        chk({tag, "_pc"}, if_pc, addr);
        chk({tag, "_inst"}, if_inst, data);
        chk({tag, "_rdy_req"}, {31'd0, ibus_req}, 32'd0);
        tick();
    endtask

    initial begin
        rst = 1'b1; stall = '0; branch_flag_i = 1'b0; branch_target_i = '0;
        flush = 1'b0; new_pc = '0; ibus_ack = 1'b0; ibus_rdata = '0;
        tick(); tick();
        chk("rst_req", {31'd0, ibus_req}, 32'd0);
        chk("rst_stallreq", {31'd0, stallreq}, 32'd0);
        chk("rst_addr", ibus_addr, 32'd0);
        chk("rst_pc", if_pc, 32'd0);
        chk("rst_inst", if_inst, 32'd0);

        // 1: sequential fetches with single-cycle ack
        rst = 1'b0;
        tick();
        chk("t1_stallreq", {31'd0, stallreq}, 32'd1);
        chk("t1_bubble", if_inst, 32'd0);
        fetch_one("t1_f0", 32'h0, 32'hA000_0000);
        fetch_one("t1_f4", 32'h4, 32'hA000_0004);
        fetch_one("t1_f8", 32'h8, 32'hA000_0008);
        fetch_one("t1_fc", 32'hC, 32'hA000_000C);

        // 2: slave holds off ack for three cycles at 0x10
        for (int i = 0; i < 3; i++) begin
            chk("t2_req", {31'd0, ibus_req}, 32'd1);
            chk("t2_addr", ibus_addr, 32'h10);
            chk("t2_stallreq", {31'd0, stallreq}, 32'd1);
            chk("t2_inst", if_inst, 32'd0);
            if (i == 2) begin ibus_ack = 1'b1; ibus_rdata = 32'hB000_0010; end
            tick();
        end
        ibus_ack = 1'b0;
        chk("t2_pc", if_pc, 32'h10);
        chk("t2_data", if_inst, 32'hB000_0010);
        tick();
        fetch_one("t2_f14", 32'h14, 32'hA000_0014);
        fetch_one("t2_f18", 32'h18, 32'hA000_0018);
        fetch_one("t2_f1c", 32'h1C, 32'hA000_001C);

        // 3: branch while fetch of 0x20 is outstanding; 0x20 is the delay slot
        branch_flag_i = 1'b1; branch_target_i = 32'h100;
        tick();
        branch_flag_i = 1'b0; branch_target_i = 32'h0;
        fetch_one("t3_slot", 32'h20, 32'hC000_0020);
        chk("t3_target", ibus_addr, 32'h100);

        // 4: stall held in READY for four cycles
        ibus_ack = 1'b1; ibus_rdata = 32'hD000_0100;
        tick();
        ibus_ack = 1'b0;
        stall = 6'b000001;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t4_pc", if_pc, 32'h100);
            chk("t4_inst", if_inst, 32'hD000_0100);
            chk("t4_req", {31'd0, ibus_req}, 32'd0);
        end
        stall = '0;
        tick();
        chk("t4_next", ibus_addr, 32'h104);

        // 5: pending branch, then flush on an un-acked fetch
        branch_flag_i = 1'b1; branch_target_i = 32'h200;
        tick();
        branch_flag_i = 1'b0;
        flush = 1'b1; new_pc = 32'h80;
        tick();
        flush = 1'b0;
        chk("t5_disc_req", {31'd0, ibus_req}, 32'd1);
        chk("t5_disc_stallreq", {31'd0, stallreq}, 32'd1);
        chk("t5_disc_inst", if_inst, 32'd0);
        ibus_ack = 1'b1; ibus_rdata = 32'hBAD0_0104;
        tick();
        ibus_ack = 1'b0;
        chk("t5_dropped", if_inst, 32'd0);
        fetch_one("t5_f80", 32'h80, 32'hE000_0080);
        chk("t5_br_cleared", ibus_addr, 32'h84);

        // 6: reset mid-fetch, then PC wrap
        rst = 1'b1;
        tick();
        chk("t6_req", {31'd0, ibus_req}, 32'd0);
        chk("t6_stallreq", {31'd0, stallreq}, 32'd0);
        chk("t6_addr", ibus_addr, 32'd0);
        chk("t6_pc", if_pc, 32'd0);
        rst = 1'b0;
        tick();
        chk("t6_first", ibus_addr, 32'h0);
        flush = 1'b1; new_pc = 32'hFFFF_FFFC; ibus_ack = 1'b1; ibus_rdata = 32'hBAD0_0000;
        tick();
        flush = 1'b0; ibus_ack = 1'b0;
        fetch_one("t6_top", 32'hFFFF_FFFC, 32'hF000_FFFC);
        chk("t6_wrap", ibus_addr, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
